score_reader: RTL and testbench

- Read-side companion to the score tracker's score RAM.
- On request, walks the per-player score entries (addresses 0..NUM_PLAYERS-1) through a read-only RAM port.
- Streams each entry out for the leaderboard display, and reports the top player and top score.
- Never writes RAM. Sits between the score RAM read port and the display/game controller.

---
 rtl/score_reader.sv | 166 ++++++++++++++++
 tb/tb_score_reader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/score_reader.sv
`default_nettype none
// ============================================================================
// Module   : score_reader
// Brief    : Walks the per-player score RAM, streams each entry and reports the
//            top player/score. Macro SCORE_READER_CHECK_EN adds a stored-max check.
// Revision : 1.0 - initial release
// ============================================================================
module score_reader #(
    parameter int NUM_PLAYERS = 5,
    parameter int SCORE_W     = 3,
    parameter int ADDR_W      = 3,
    parameter int RD_LAT      = 2,
    parameter int MAX_ADDR    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic [SCORE_W-1:0] rd_data,
    output logic [ADDR_W-1:0]  rd_addr,
    output logic               busy,
    output logic               done,
    output logic               entry_valid,
    output logic [ADDR_W-1:0]  entry_id,
    output logic [SCORE_W-1:0] entry_score,
    output logic [ADDR_W-1:0]  top_id,
    output logic [SCORE_W-1:0] top_score,
    output logic               max_mismatch
);

    localparam int                c_CNT_W     = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'((RD_LAT > 1) ? (RD_LAT - 2) : 0);
    localparam logic [ADDR_W-1:0]  c_LAST_IDX  = ADDR_W'(NUM_PLAYERS - 1);

    if (RD_LAT < 1 || NUM_PLAYERS < 1 || NUM_PLAYERS > (1 << ADDR_W) ||
        MAX_ADDR >= (1 << ADDR_W)) begin : g_paramCheck
        $error("score_reader: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        ST_IDLE          = 3'd0,
        ST_ISSUE         = 3'd1,
        ST_WAIT          = 3'd2,
        ST_CAPTURE       = 3'd3,
        ST_DONE          = 3'd4
`ifdef SCORE_READER_CHECK_EN
        ,
        ST_CHECK_ISSUE   = 3'd5,
        ST_CHECK_WAIT    = 3'd6,
        ST_CHECK_CAPTURE = 3'd7
`endif
    } state_t;

    state_t               r_state;
    logic [ADDR_W-1:0]    r_idx;
    logic [c_CNT_W-1:0]   r_waitCnt;
    logic [ADDR_W-1:0]    r_bestId;
    logic [SCORE_W-1:0]   r_bestScore;
`ifdef SCORE_READER_CHECK_EN
    logic                 r_chkMismatch;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_waitCnt    <= '0;
            r_bestId     <= '0;
            r_bestScore  <= '0;
            rd_addr      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            entry_valid  <= 1'b0;
            entry_id     <= '0;
            entry_score  <= '0;
            top_id       <= '0;
            top_score    <= '0;
`ifdef SCORE_READER_CHECK_EN
            r_chkMismatch <= 1'b0;
            max_mismatch  <= 1'b0;
`endif
        end else begin
            entry_valid <= 1'b0;
            done        <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        busy        <= 1'b1;
                        r_bestId    <= '0;
                        r_bestScore <= '0;
                        r_idx       <= '0;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    rd_addr   <= r_idx;
                    r_waitCnt <= '0;
                    r_state   <= (RD_LAT > 1) ? ST_WAIT : ST_CAPTURE;
                end
                ST_WAIT: begin
                    if (r_waitCnt == c_WAIT_LAST) begin
                        r_state <= ST_CAPTURE;
                    end else begin
                        r_waitCnt <= r_waitCnt + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    entry_valid <= 1'b1;
                    entry_id    <= r_idx;
                    entry_score <= rd_data;
                    // Strict compare so ties keep the lower player ID
                    if (rd_data > r_bestScore) begin
                        r_bestId    <= r_idx;
                        r_bestScore <= rd_data;
                    end
                    if (r_idx == c_LAST_IDX) begin
`ifdef SCORE_READER_CHECK_EN
                        r_state <= ST_CHECK_ISSUE;
`else
                        r_state <= ST_DONE;
`endif
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= ST_ISSUE;
                    end
                end
`ifdef SCORE_READER_CHECK_EN
                ST_CHECK_ISSUE: begin
                    rd_addr   <= ADDR_W'(MAX_ADDR);
                    r_waitCnt <= '0;
                    r_state   <= (RD_LAT > 1) ? ST_CHECK_WAIT : ST_CHECK_CAPTURE;
                end
                ST_CHECK_WAIT: begin
                    if (r_waitCnt == c_WAIT_LAST) begin
                        r_state <= ST_CHECK_CAPTURE;
                    end else begin
                        r_waitCnt <= r_waitCnt + 1'b1;
                    end
                end
                ST_CHECK_CAPTURE: begin
                    r_chkMismatch <= (rd_data != r_bestScore);
                    r_state       <= ST_DONE;
                end
`endif
                ST_DONE: begin
                    top_id    <= r_bestId;
                    top_score <= r_bestScore;
`ifdef SCORE_READER_CHECK_EN
                    max_mismatch <= r_chkMismatch;
`endif
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifndef SCORE_READER_CHECK_EN
    assign max_mismatch = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_score_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_reader
// Brief    : Self-checking bench for score_reader: vector table, reset abort
//            sequence and random scans against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_score_reader;

    localparam int NUM_PLAYERS = 5;
    localparam int SCORE_W     = 3;
    localparam int ADDR_W      = 3;
    localparam int RD_LAT      = 2;
    localparam int MAX_ADDR    = 5;
    localparam int PERIOD      = RD_LAT + 1;
`ifdef SCORE_READER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam int DONE_EDGE = NUM_PLAYERS * PERIOD + 1 + (CHK ? PERIOD : 0);

    logic               clk;
    logic               rst;
    logic               req;
    logic [SCORE_W-1:0] rd_data;
    logic [ADDR_W-1:0]  rd_addr;
    logic               busy;
    logic               done;
    logic               entry_valid;
    logic [ADDR_W-1:0]  entry_id;
    logic [SCORE_W-1:0] entry_score;
    logic [ADDR_W-1:0]  top_id;
    logic [SCORE_W-1:0] top_score;
    logic               max_mismatch;

    score_reader #(
        .NUM_PLAYERS(NUM_PLAYERS), .SCORE_W(SCORE_W), .ADDR_W(ADDR_W),
        .RD_LAT(RD_LAT), .MAX_ADDR(MAX_ADDR)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .rd_data(rd_data), .rd_addr(rd_addr),
        .busy(busy), .done(done), .entry_valid(entry_valid), .entry_id(entry_id),
        .entry_score(entry_score), .top_id(top_id), .top_score(top_score),
        .max_mismatch(max_mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Score RAM with RD_LAT-1 read register stages: data is sampleable on the
    // RD_LAT-th edge after the address changes.
    logic [SCORE_W-1:0] ram  [0:(1<<ADDR_W)-1];
    logic [SCORE_W-1:0] pipe [0:RD_LAT-2];
    always @(posedge clk) begin
        pipe[0] <= ram[rd_addr];
        for (int i = 1; i < RD_LAT - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign rd_data = pipe[RD_LAT-2];

    int checks = 0;
    int errors = 0;

    int prevTopId = 0;
    int prevTopS  = 0;
    int prevMm    = 0;
    int lastAddr  = 0;

    typedef struct packed {
        logic [NUM_PLAYERS-1:0][SCORE_W-1:0] sc;
        logic [SCORE_W-1:0]                  mx;
        logic                                hold;
        logic [ADDR_W-1:0]                   topId;
        logic [SCORE_W-1:0]                  topS;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkVec(input int s0, input int s1, input int s2, input int s3,
                                   input int s4, input int mx, input int hold,
                                   input int tid, input int ts);
        vec_t v;
        v.sc[0] = SCORE_W'(s0);
        v.sc[1] = SCORE_W'(s1);
        v.sc[2] = SCORE_W'(s2);
        v.sc[3] = SCORE_W'(s3);
        v.sc[4] = SCORE_W'(s4);
        v.mx    = SCORE_W'(mx);
        v.hold  = hold[0];
        v.topId = ADDR_W'(tid);
        v.topS  = SCORE_W'(ts);
        return v;
    endfunction

    // Reference: highest value, then the first player holding it.
    task automatic refTop(output int id, output int sc);
        int mx;
        mx = 0;
        for (int i = 0; i < NUM_PLAYERS; i++) if (int'(ram[i]) > mx) mx = int'(ram[i]);
        id = 0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) if (int'(ram[i]) == mx) id = i;
        sc = mx;
    endtask

    // Address being read after edge k of a scan (k >= 1).
    function automatic int expAddrAt(input int k);
        int j;
        j = (k - 1) / PERIOD;
        if (j >= NUM_PLAYERS) return CHK ? MAX_ADDR : NUM_PLAYERS - 1;
        return j;
    endfunction

    task automatic checkAllZero(input string tag);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_entry_valid"}, entry_valid, 0);
        check({tag, "_entry_id"}, entry_id, 0);
        check({tag, "_entry_score"}, entry_score, 0);
        check({tag, "_top_id"}, top_id, 0);
        check({tag, "_top_score"}, top_score, 0);
        check({tag, "_max_mismatch"}, max_mismatch, 0);
    endtask

    task automatic loadRam(input vec_t v);
        for (int i = 0; i < NUM_PLAYERS; i++) ram[i] = v.sc[i];
        ram[MAX_ADDR] = v.mx;
    endtask

    // One full scan: edge 0 samples req; checked cycle by cycle up to done.
    task automatic runScan(input bit hold, input int newTopId, input int newTopS);
        bit isEntry;
        int newMm;
        newMm = CHK ? int'(int'(ram[MAX_ADDR]) != newTopS) : 0;
        req = 1'b1;
        for (int k = 0; k <= DONE_EDGE; k++) begin
            tick();
            if (!hold) req = 1'b0;
            isEntry = (k % PERIOD == 0) && (k / PERIOD >= 1) && (k / PERIOD <= NUM_PLAYERS);
            check("busy", busy, int'(k < DONE_EDGE));
            check("done", done, int'(k == DONE_EDGE));
            check("entry_valid", entry_valid, int'(isEntry));
            if (isEntry) begin
                check("entry_id", entry_id, k / PERIOD - 1);
                check("entry_score", entry_score, ram[k / PERIOD - 1]);
            end
            check("rd_addr", rd_addr, (k == 0) ? lastAddr : expAddrAt(k));
            check("top_id", top_id, (k >= DONE_EDGE) ? newTopId : prevTopId);
            check("top_score", top_score, (k >= DONE_EDGE) ? newTopS : prevTopS);
            check("max_mismatch", max_mismatch, (k >= DONE_EDGE) ? newMm : prevMm);
        end
        prevTopId = newTopId;
        prevTopS  = newTopS;
        prevMm    = newMm;
        lastAddr  = expAddrAt(DONE_EDGE);
    endtask

    initial begin
        int rid;
        int rsc;
        bit hold;

        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = '0;
        rst = 1'b1;
        req = 1'b0;

        vecs[0] = mkVec(3, 5, 1, 7, 2, 4, 0, 3, 7);
        vecs[1] = mkVec(3, 5, 1, 7, 2, 7, 0, 3, 7);
        vecs[2] = mkVec(4, 6, 6, 2, 6, 6, 1, 1, 6);
        vecs[3] = mkVec(0, 0, 0, 0, 0, 0, 1, 0, 0);
        vecs[4] = mkVec(1, 1, 7, 7, 0, 3, 0, 2, 7);
        vecs[5] = mkVec(0, 0, 0, 0, 5, 5, 0, 4, 5);

        tick();
        tick();
        checkAllZero("reset");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_busy", busy, 0);
            check("idle_entry_valid", entry_valid, 0);
        end

        for (int v = 0; v < 6; v++) begin
            loadRam(vecs[v]);
            runScan(vecs[v].hold, vecs[v].topId, vecs[v].topS);
        end
        req = 1'b0;
        tick();
        check("no_restart_busy", busy, 0);

        // Reset at edge 8 aborts the scan in the middle of entry 2
        loadRam(vecs[0]);
        req = 1'b1;
        tick();
        req = 1'b0;
        for (int k = 1; k < 8; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkAllZero("abort");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("abort_done", done, 0);
            check("abort_busy", busy, 0);
            check("abort_entry_valid", entry_valid, 0);
        end
        prevTopId = 0;
        prevTopS  = 0;
        prevMm    = 0;
        lastAddr  = 0;
        runScan(1'b0, 3, 7);

        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < NUM_PLAYERS; i++) ram[i] = SCORE_W'($urandom_range(0, 7));
            ram[MAX_ADDR] = SCORE_W'($urandom_range(0, 7));
            hold = 1'($urandom_range(0, 1));
            refTop(rid, rsc);
            runScan(hold, rid, rsc);
        end
        req = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
